// File: rtl/conv_s2_scheduler_if.sv
// Window/result handshake and tap-select bundle shared by the stage-2 scheduler,
// the window buffer, the coefficient mux and the single-product MAC.
interface conv_s2_scheduler_if;
   logic       win_valid;
   logic       win_ready;
   logic [1:0] filt_sel;
   logic [1:0] tap_row;
   logic [1:0] tap_col;
   logic [1:0] tap_ch;
   logic       mac_en;
   logic       mac_clr;
   logic       mac_last;
   logic       res_valid;
   logic       res_ready;
   logic [1:0] res_filt;
   logic       busy;
   logic       frame_done;

   modport master (
      input  win_valid, res_ready,
      output win_ready, filt_sel, tap_row, tap_col, tap_ch,
             mac_en, mac_clr, mac_last, res_valid, res_filt, busy, frame_done
   );

   modport slave (
      output win_valid, res_ready,
      input  win_ready, filt_sel, tap_row, tap_col, tap_ch,
             mac_en, mac_clr, mac_last, res_valid, res_filt, busy, frame_done
   );
endinterface

// File: rtl/conv_s2_scheduler.sv
// Stage-2 convolution sequencer: walks every filter over a 3x3x3 window one tap per
// cycle, waits out the MAC latency and hands each filter result downstream.
module conv_s2_scheduler #(
   parameter int N_FILT        = 4,
   parameter int N_ROW         = 3,
   parameter int N_COL         = 3,
   parameter int N_CH          = 3,
   parameter int MAC_LAT       = 2,
   parameter int FRAME_WINDOWS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   conv_s2_scheduler_if.master    bus
);
   localparam int WC_W = (FRAME_WINDOWS > 1) ? $clog2(FRAME_WINDOWS) : 1;
   localparam int DL_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_DRAIN    = 2'd2,
      S_WAIT_OUT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       filt_q, filt_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       ch_q, ch_d;
   logic [DL_W-1:0]  dly_q, dly_d;
   logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
   logic             frame_done_q, frame_done_d;

   // State, counters and the frame pulse; everything returns to idle on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         filt_q       <= 2'd0;
         row_q        <= 2'd0;
         col_q        <= 2'd0;
         ch_q         <= 2'd0;
         dly_q        <= '0;
         win_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         filt_q       <= filt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         ch_q         <= ch_d;
         dly_q        <= dly_d;
         win_cnt_q    <= win_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic: tap walk with channel fastest, drain timer, result handshake.
   always_comb begin
      state_d      = state_q;
      filt_d       = filt_q;
      row_d        = row_q;
      col_d        = col_q;
      ch_d         = ch_q;
      dly_d        = dly_q;
      win_cnt_d    = win_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.win_valid) begin
               state_d = S_RUN;
               filt_d  = 2'd0;
               row_d   = 2'd0;
               col_d   = 2'd0;
               ch_d    = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (ch_q == 2'(N_CH - 1)) begin
               ch_d = 2'd0;
               if (col_q == 2'(N_COL - 1)) begin
                  col_d = 2'd0;
                  if (row_q == 2'(N_ROW - 1)) begin
                     row_d   = 2'd0;
                     dly_d   = '0;
                     state_d = S_DRAIN;
                  end else begin
                     row_d = row_q + 2'd1;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               ch_d = ch_q + 2'd1;
            end
         end
         S_DRAIN: begin
            if (dly_q == DL_W'(MAC_LAT - 1)) begin
               dly_d   = '0;
               state_d = S_WAIT_OUT;
            end else begin
               dly_d = dly_q + {{(DL_W-1){1'b0}}, 1'b1};
            end
         end
         S_WAIT_OUT: begin
            if (bus.res_ready) begin
               if (filt_q == 2'(N_FILT - 1)) begin
                  // Window complete: count it and flag the last window of a frame.
                  state_d = S_IDLE;
                  filt_d  = 2'd0;
                  if (win_cnt_q == WC_W'(FRAME_WINDOWS - 1)) begin
                     win_cnt_d    = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     win_cnt_d = win_cnt_q + {{(WC_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  filt_d  = filt_q + 2'd1;
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_WAIT_OUT;
            end
         end
         default: begin
            state_d = S_IDLE;
            filt_d  = 2'd0;
            row_d   = 2'd0;
            col_d   = 2'd0;
            ch_d    = 2'd0;
            dly_d   = '0;
         end
      endcase
   end

   // Outputs decoded purely from registered state; no input reaches an output combinationally.
   always_comb begin
      bus.win_ready  = (state_q == S_IDLE);
      bus.busy       = (state_q != S_IDLE);
      bus.filt_sel   = filt_q;
      bus.res_filt   = filt_q;
      bus.res_valid  = (state_q == S_WAIT_OUT);
      bus.frame_done = frame_done_q;
      bus.mac_en     = 1'b0;
      bus.mac_clr    = 1'b0;
      bus.mac_last   = 1'b0;
      bus.tap_row    = 2'd0;
      bus.tap_col    = 2'd0;
      bus.tap_ch     = 2'd0;
      if (state_q == S_RUN) begin
         bus.mac_en   = 1'b1;
         bus.mac_clr  = (row_q == 2'd0) && (col_q == 2'd0) && (ch_q == 2'd0);
         bus.mac_last = (row_q == 2'(N_ROW - 1)) && (col_q == 2'(N_COL - 1)) &&
                        (ch_q == 2'(N_CH - 1));
         bus.tap_row  = row_q;
         bus.tap_col  = col_q;
         bus.tap_ch   = ch_q;
      end else begin
         bus.mac_en   = 1'b0;
      end
   end
endmodule

// File: tb/tb_conv_s2_scheduler.sv
// Bench for conv_s2_scheduler: a MAC_LAT=2 and a MAC_LAT=1 instance share stimulus and
// are each compared every cycle with a tap-index reference model, plus directed vectors.
module tb_conv_s2_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wv = 1'b0;
   logic rr = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   accepts0 = 0;
   int   completions0 = 0;
   int   pulses0 = 0;

   always #5 clk = ~clk;

   conv_s2_scheduler_if bus0 ();
   conv_s2_scheduler_if bus1 ();
   assign bus0.win_valid = wv;
   assign bus0.res_ready = rr;
   assign bus1.win_valid = wv;
   assign bus1.res_ready = rr;

   conv_s2_scheduler #(.MAC_LAT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   conv_s2_scheduler #(.MAC_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic [16:0] act0, act1;
   assign act0 = {bus0.win_ready, bus0.busy, bus0.filt_sel, bus0.tap_row, bus0.tap_col,
                  bus0.tap_ch, bus0.mac_en, bus0.mac_clr, bus0.mac_last, bus0.res_valid,
                  bus0.res_filt, bus0.frame_done};
   assign act1 = {bus1.win_ready, bus1.busy, bus1.filt_sel, bus1.tap_row, bus1.tap_col,
                  bus1.tap_ch, bus1.mac_en, bus1.mac_clr, bus1.mac_last, bus1.res_valid,
                  bus1.res_filt, bus1.frame_done};

   // Model: p is the position inside the current filter: 0..26 taps, then MAC_LAT drain
   // cycles, then p == 27+lat while the result waits for res_ready.
   typedef struct { bit busy; int f; int p; int wins; bit pulse; } mdl_t;
   mdl_t m[2];
   int   lat_a[2];

   typedef struct { int cyc; bit wv; bit rr; bit chk0; logic [16:0] exp0; bit chk1; bit rv1; } vec_t;
   vec_t tbl[$];
   logic [5:0] tapq[$];

   function automatic logic [16:0] pk(int wr, int bsy, int fs, int r, int c, int ch, int en,
                                      int clr, int last, int rv, int rf, int fd);
      return {wr[0], bsy[0], fs[1:0], r[1:0], c[1:0], ch[1:0], en[0], clr[0], last[0],
              rv[0], rf[1:0], fd[0]};
   endfunction

   function automatic mdl_t mdl_next(mdl_t s, int lat, bit v, bit rdy);
      mdl_t n = s;
      n.pulse = 1'b0;
      if (!s.busy) begin
         if (v) begin n.busy = 1'b1; n.f = 0; n.p = 0; end
      end else if (s.p < 27 + lat) begin
         n.p = s.p + 1;
      end else if (rdy) begin
         if (s.f == 3) begin
            n.busy = 1'b0; n.f = 0; n.p = 0;
            n.pulse = (s.wins == 15);
            n.wins = (s.wins + 1) % 16;
         end else begin
            n.f = s.f + 1; n.p = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [16:0] exp_vec(mdl_t s, int lat);
      bit run = s.busy && (s.p < 27);
      int r  = run ? s.p / 9 : 0;
      int c  = run ? (s.p / 3) % 3 : 0;
      int ch = run ? s.p % 3 : 0;
      return pk(!s.busy, s.busy, s.f, r, c, ch, run, run && s.p == 0, run && s.p == 26,
                s.busy && s.p == 27 + lat, s.f, s.pulse);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 2; i++) m[i] = '{default:0};
      accepts0 = 0; completions0 = 0; pulses0 = 0;
   endtask

   task automatic tick();
      logic       s_wr0, s_rv0;
      logic [1:0] s_rf0;
      s_wr0 = bus0.win_ready; s_rv0 = bus0.res_valid; s_rf0 = bus0.res_filt;
      @(posedge clk);
      if (wv && s_wr0) accepts0++;
      if (rr && s_rv0 && s_rf0 == 2'd3) completions0++;
      for (int i = 0; i < 2; i++) m[i] = rst_n ? mdl_next(m[i], lat_a[i], wv, rr) : '{default:0};
      @(negedge clk);
      cyc++;
      chk("cycle_model_lat2", act0, exp_vec(m[0], lat_a[0]));
      chk("cycle_model_lat1", act1, exp_vec(m[1], lat_a[1]));
      if (bus0.frame_done) begin
         pulses0++;
         chk("frame_done_position", (completions0 % 16 == 0) && (completions0 > 0), 1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wv = 1'b0; rr = 1'b0;
      mdl_reset();
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int n_en, n_clr, n_last, hold, k;
      bit released, chk_next, done;
      lat_a[0] = 2; lat_a[1] = 1;
      // Single window, res_ready high: cycle 0 is the acceptance cycle.
      tbl.push_back('{0,   1'b1, 1'b1, 1'b1, pk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0});
      tbl.push_back('{1,   1'b0, 1'b1, 1'b1, pk(0,1,0,0,0,0,1,1,0,0,0,0), 1'b0, 1'b0});
      tbl.push_back('{2,   1'b0, 1'b1, 1'b1, pk(0,1,0,0,0,1,1,0,0,0,0,0), 1'b0, 1'b0});
      tbl.push_back('{4,   1'b0, 1'b1, 1'b1, pk(0,1,0,0,1,0,1,0,0,0,0,0), 1'b0, 1'b0});
      tbl.push_back('{27,  1'b0, 1'b1, 1'b1, pk(0,1,0,2,2,2,1,0,1,0,0,0), 1'b0, 1'b0});
      tbl.push_back('{28,  1'b0, 1'b1, 1'b1, pk(0,1,0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0});
      tbl.push_back('{29,  1'b0, 1'b1, 1'b1, pk(0,1,0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b1});
      tbl.push_back('{30,  1'b0, 1'b1, 1'b1, pk(0,1,0,0,0,0,0,0,0,1,0,0), 1'b0, 1'b0});
      tbl.push_back('{31,  1'b0, 1'b1, 1'b1, pk(0,1,1,0,0,0,1,1,0,0,1,0), 1'b0, 1'b0});
      tbl.push_back('{45,  1'b0, 1'b1, 1'b1, pk(0,1,1,1,1,2,1,0,0,0,1,0), 1'b0, 1'b0});
      tbl.push_back('{58,  1'b0, 1'b1, 1'b0, 17'd0,                       1'b1, 1'b1});
      tbl.push_back('{60,  1'b0, 1'b1, 1'b1, pk(0,1,1,0,0,0,0,0,0,1,1,0), 1'b0, 1'b0});
      tbl.push_back('{87,  1'b0, 1'b1, 1'b0, 17'd0,                       1'b1, 1'b1});
      tbl.push_back('{90,  1'b0, 1'b1, 1'b1, pk(0,1,2,0,0,0,0,0,0,1,2,0), 1'b0, 1'b0});
      tbl.push_back('{116, 1'b0, 1'b1, 1'b0, 17'd0,                       1'b1, 1'b1});
      tbl.push_back('{120, 1'b0, 1'b1, 1'b1, pk(0,1,3,0,0,0,0,0,0,1,3,0), 1'b0, 1'b0});
      tbl.push_back('{121, 1'b0, 1'b1, 1'b1, pk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0});

      @(negedge clk);
      do_reset();
      chk("reset_state_lat2", act0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
      chk("reset_state_lat1", act1, pk(1,0,0,0,0,0,0,0,0,0,0,0));

      n_en = 0; n_clr = 0; n_last = 0;
      for (int c = 0; c <= 121; c++) begin
         wv = 1'b0; rr = 1'b1;
         foreach (tbl[i]) begin
            if (tbl[i].cyc == c) begin
               wv = tbl[i].wv; rr = tbl[i].rr;
               if (tbl[i].chk0) chk($sformatf("vec_c%0d_lat2", c), act0, tbl[i].exp0);
               if (tbl[i].chk1) chk($sformatf("vec_c%0d_lat1_res_valid", c), bus1.res_valid, tbl[i].rv1);
            end
         end
         if (bus0.mac_en) n_en++;
         if (bus0.mac_clr) n_clr++;
         if (bus0.mac_last) n_last++;
         if (bus0.mac_en && bus0.filt_sel == 2'd1)
            tapq.push_back({bus0.tap_row, bus0.tap_col, bus0.tap_ch});
         tick();
      end
      chk("mac_en_count", n_en, 108);
      chk("mac_clr_count", n_clr, 4);
      chk("mac_last_count", n_last, 4);
      chk("filter1_tap_count", tapq.size(), 27);
      k = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            for (int ch = 0; ch < 3; ch++) begin
               if (k < tapq.size())
                  chk($sformatf("filter1_tap%0d", k), tapq[k], (r << 4) | (c << 2) | ch);
               k++;
            end

      // Backpressure on filter 2 for five cycles.
      wv = 1'b1; rr = 1'b1; tick(); wv = 1'b0;
      hold = 0; released = 1'b0; chk_next = 1'b0; done = 1'b0;
      for (int j = 0; j < 400 && !done; j++) begin
         rr = 1'b1;
         if (chk_next) begin
            chk("bp_filter3_tap0", {bus0.mac_clr, bus0.filt_sel, bus0.tap_row, bus0.tap_col, bus0.tap_ch},
                {1'b1, 2'd3, 6'd0});
            chk_next = 1'b0;
         end else if (bus0.res_valid && bus0.res_filt == 2'd2 && hold < 5) begin
            chk("bp_hold", {bus0.res_valid, bus0.res_filt, bus0.mac_en, bus0.filt_sel},
                {1'b1, 2'd2, 1'b0, 2'd2});
            hold++; rr = 1'b0;
         end else if (hold == 5 && !released) begin
            released = 1'b1; chk_next = 1'b1;
         end else if (released && bus0.win_ready) begin
            done = 1'b1;
         end
         if (!done) tick();
      end
      chk("bp_hold_cycles", hold, 5);
      chk("bp_window_done", done, 1);

      // Reset during filter 1 tap 14.
      rr = 1'b1; wv = 1'b1; tick(); wv = 1'b0;
      for (int c = 1; c < 45; c++) tick();
      chk("pre_reset_f1_tap14", act0, pk(0,1,1,1,1,2,1,0,0,0,1,0));
      rst_n = 1'b0; mdl_reset(); #1;
      chk("mid_reset_lat2", act0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
      chk("mid_reset_lat1", act1, pk(1,0,0,0,0,0,0,0,0,0,0,0));
      tick(); tick(); tick();
      rst_n = 1'b1; wv = 1'b1; tick(); wv = 1'b0;
      chk("post_reset_first_tap", act0, pk(0,1,0,0,0,0,1,1,0,0,0,0));
      done = 1'b0;
      for (int j = 0; j < 200 && !done; j++) begin
         if (bus0.win_ready) done = 1'b1; else tick();
      end
      chk("post_reset_window_done", done, 1);

      // Continuous win_valid, random backpressure, 32 windows.
      do_reset();
      wv = 1'b1;
      for (int j = 0; j < 20000 && completions0 < 32; j++) begin
         rr = ($urandom_range(3) != 0);
         tick();
      end
      chk("frame_windows_completed", completions0, 32);
      chk("frame_accepts", accepts0, 32);
      chk("frame_done_pulses", pulses0, 2);

      // Fully random traffic against the model.
      for (int j = 0; j < 2000; j++) begin
         wv = ($urandom_range(1) != 0);
         rr = ($urandom_range(3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv_s2_scheduler.md
# conv_s2_scheduler

Sequencing controller for the stage-2 convolution datapath. For each accepted 3x3x3 input window it walks all four stage-2 filters tap by tap, 27 taps per filter. On every tap it drives the filter/row/column/channel selects into the filter-coefficient mux and the shared single-product MAC. It issues clear/enable/last strobes, waits out the MAC pipeline latency, and hands each filter's accumulated result downstream through a valid/ready handshake. It also counts windows per frame.

## Interface
- N_FILT, 4, filters per window (one result per filter)
- N_ROW, 3, kernel rows
- N_COL, 3, kernel columns
- N_CH, 3, kernel input channels
- MAC_LAT, 2, cycles from the mac_last cycle until the accumulator output is valid; must be >= 1
- FRAME_WINDOWS, 16, windows per frame

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- win_valid  in  1  upstream window buffer holds a complete window
- win_ready  out  1  scheduler accepts a window (high only in IDLE)
- filt_sel  out  2  filter index to coefficient mux
- tap_row  out  2  kernel row 0..N_ROW-1
- tap_col  out  2  kernel column 0..N_COL-1
- tap_ch  out  2  channel 0..N_CH-1
- mac_en  out  1  MAC accumulates the current product this cycle
- mac_clr  out  1  first tap of a filter: accumulator loads the product instead of adding it
- mac_last  out  1  last tap of a filter
- res_valid  out  1  accumulator result for filt_sel is valid
- res_ready  in  1  downstream consumes the result
- res_filt  out  2  filter index of the presented result
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when window FRAME_WINDOWS-1 of a frame completes

## Operation
- FSM states: IDLE, RUN, DRAIN, WAIT_OUT. All outputs are registered or decoded from registered state. The only input that affects an output in the same cycle is none; res_ready is sampled on the clock edge.
- IDLE:
  - win_ready=1.
  - On win_valid&&win_ready, go to RUN with filter counter f=0 and tap counter cleared.
- RUN, one tap per cycle, order channel fastest, then column, then row: (r,c,ch) = (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(2,2,2).
  - mac_en=1 on every RUN cycle.
  - mac_clr=1 on tap 0.
  - mac_last=1 on tap 26.
  - filt_sel=f.
  - After tap 26, go to DRAIN.
- DRAIN: hold for exactly MAC_LAT cycles with mac_en=0, then go to WAIT_OUT.
- WAIT_OUT:
  - res_valid=1, res_filt=f.
  - Hold until the clock edge on which res_ready=1.
  - If f<N_FILT-1: set f=f+1 and go to RUN.
  - Otherwise the window is complete: go to IDLE.
- Window completion increments the window counter (width ceil(log2 FRAME_WINDOWS)). At count FRAME_WINDOWS-1 it pulses frame_done on the completion cycle and wraps to 0.
- win_valid while busy is ignored; the window buffer must hold its data until win_ready returns.
- Tap indices never exceed N_ROW-1/N_COL-1/N_CH-1. Counters wrap to 0 exactly at the bound.
- Outside RUN: tap_row/tap_col/tap_ch=0, mac_en=mac_clr=mac_last=0.

## Timing
- Reset values (asserted or released mid-operation):
  - state=IDLE, f=0, all counters=0.
  - win_ready=1, busy=0.
  - All strobes, res_valid, frame_done and selects = 0.
- An in-flight window is dropped on reset; no partial result is emitted.
- Window accepted at cycle 0 → first RUN cycle (tap 0, mac_clr) at cycle 1 → mac_last at cycle 27 → DRAIN cycles 28..27+MAC_LAT → res_valid from cycle 28+MAC_LAT.
- Per filter with res_ready held high: 27+MAC_LAT+1 cycles (30 at MAC_LAT=2).
- With res_ready held high and MAC_LAT=2:
  - Filter f res_valid handshake at cycle 30+30f, with the next filter's tap 0 on the following cycle.
  - Last handshake at cycle 120; win_ready=1 at cycle 121.
- res_ready already high when res_valid rises: handshake completes that same cycle, with no bubble.
- res_ready low: state, filt_sel and res_filt are held, and no MAC strobes are issued.
- busy rises the cycle after acceptance and falls the cycle after the final handshake.

## Test plan
- Reset, then one window with res_ready=1, MAC_LAT=2:
  - win_ready falls after cycle 0.
  - Exactly 108 mac_en cycles, 4 mac_clr, 4 mac_last.
  - res_valid at cycles 30,60,90,120 with res_filt 0,1,2,3.
  - win_ready=1 at cycle 121.
- Tap order check: log (tap_row,tap_col,tap_ch) during filter 1. Required: 27 entries (0,0,0)…(2,2,2) with channel fastest, all with filt_sel=1.
- Backpressure: hold res_ready=0 for 5 cycles on filter 2. Required: res_valid stays 1, res_filt=2, mac_en=0 throughout; filter 3 tap 0 appears the cycle after res_ready rises.
- win_valid held high continuously across windows: exactly one acceptance per window, at the cycles where win_ready=1. frame_done pulses once after 16 windows, and the counter wraps (pulses again after window 32).
- Assert rst_n=0 at cycle 45 (filter 1 tap 14), release at cycle 48. Required: all outputs at reset values; no res_valid for the aborted window; the next window runs from filter 0 tap 0.
- MAC_LAT=1 build: res_valid at cycles 29,58,87,116 for one window with res_ready=1.
